// File: rtl/mod_vector_seq.sv
// ============================================================================
// Module   : mod_vector_seq
// Purpose  : Sequential per-lane modular reducer. Accepts a vector of N
//            signed or unsigned double-width products plus a runtime modulus
//            q and reduces every lane to its canonical residue in [0, q).
//            The reduction uses a restoring shift-subtract engine that works
//            on P lanes per chunk and resolves BPC quotient bits per cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     transaction offered
//   in_ready     block can accept (IDLE only)
//   in_vec       N lanes of WW bits, lane i at [i*WW +: WW]
//   q_in         modulus, sampled on accept
//   signed_mode  1: lanes are two's complement, 0: unsigned
//   out_valid    result held (DONE)
//   out_ready    consumer takes result
//   out_vec      N residues of W bits, lane i at [i*W +: W]
//   err          qualified by out_valid; 1 when q was zero
// ============================================================================
`default_nettype none

`ifndef N_SLOTS
`define N_SLOTS 8
`endif
`ifndef RNS_PRIME_BITS
`define RNS_PRIME_BITS 16
`endif

module mod_vector_seq #(
  parameter int N   = `N_SLOTS,
  parameter int W   = `RNS_PRIME_BITS,
  parameter int WW  = 2 * `RNS_PRIME_BITS,
  parameter int P   = 4,
  parameter int BPC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*WW-1:0] in_vec,
  input  logic [W-1:0]    q_in,
  input  logic            signed_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_vec,
  output logic            err
);

  // One extra bit so the magnitude of the most negative signed lane fits.
  localparam int WWP    = WW + 1;
  localparam int STEPS  = (WWP + BPC - 1) / BPC;
  localparam int CHUNKS = N / P;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int SW     = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    chunk_r;
  logic [SW-1:0]    step_r;
  logic [N*WW-1:0]  vec_r;
  logic [W-1:0]     q_r;
  logic             smode_r;
  logic [WWP-1:0]   t_r   [P];
  logic             neg_r [P];

  logic [WWP:0]     lane_prep [P];
  logic [WWP-1:0]   t_cur     [P];
  logic             neg_cur   [P];
  logic [WWP-1:0]   t_next    [P];
  logic [W-1:0]     r_lane    [P];
  logic [W-1:0]     res       [P];

  // Extend a lane to WWP bits and split it into {sign, magnitude}.
  function automatic logic [WWP:0] prep(input logic [WW-1:0] lane,
                                        input logic sm);
    logic [WWP-1:0] ext;
    ext = sm ? {lane[WW-1], lane} : {1'b0, lane};
    prep = {ext[WWP-1], (ext[WWP-1] ? -ext : ext)};
  endfunction

  // BPC restoring iterations starting at bit position kt. The work is done
  // at WWP+W bits so q<<k keeps all of its bits for every k.
  function automatic logic [WWP-1:0] reduce(input logic [WWP-1:0] t,
                                            input logic [W-1:0]   q,
                                            input int             kt);
    logic [WWP+W-1:0] acc;
    logic [WWP+W-1:0] sub;
    acc = {{W{1'b0}}, t};
    for (int j = 0; j < BPC; j++) begin
      if (kt - j >= 0) begin
        sub = {{WWP{1'b0}}, q} << (kt - j);
        if (acc >= sub) acc = acc - sub;
      end
    end
    reduce = acc[WWP-1:0];
  endfunction

  // On the first step of a chunk the lanes are prepared straight from the
  // latched vector so no separate load cycle is spent.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      lane_prep[p] = prep(vec_r[(int'(chunk_r) * P + p) * WW +: WW], smode_r);
      neg_cur[p]   = (step_r == '0) ? lane_prep[p][WWP] : neg_r[p];
      t_cur[p]     = (step_r == '0) ? lane_prep[p][WWP-1:0] : t_r[p];
      t_next[p]    = reduce(t_cur[p], q_r, WWP - 1 - int'(step_r) * BPC);
      r_lane[p]    = t_next[p][W-1:0];
      res[p]       = (neg_cur[p] && (r_lane[p] != '0)) ? (q_r - r_lane[p])
                                                       : r_lane[p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      err       <= 1'b0;
      out_vec   <= '0;
      chunk_r   <= '0;
      step_r    <= '0;
      vec_r     <= '0;
      q_r       <= '0;
      smode_r   <= 1'b0;
      for (int p = 0; p < P; p++) begin
        t_r[p]   <= '0;
        neg_r[p] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec_r    <= in_vec;
            q_r      <= q_in;
            smode_r  <= signed_mode;
            out_vec  <= '0;
            chunk_r  <= '0;
            step_r   <= '0;
            in_ready <= 1'b0;
            if (q_in == '0) begin
              state     <= DONE;
              err       <= 1'b1;
              out_valid <= 1'b1;
            end else begin
              state <= BUSY;
              err   <= 1'b0;
            end
          end
        end

        BUSY: begin
          for (int p = 0; p < P; p++) begin
            t_r[p]   <= t_next[p];
            neg_r[p] <= neg_cur[p];
          end
          if (step_r == SW'(STEPS - 1)) begin
            for (int p = 0; p < P; p++) begin
              out_vec[(int'(chunk_r) * P + p) * W +: W] <= res[p];
            end
            step_r <= '0;
            if (chunk_r == CW'(CHUNKS - 1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              chunk_r <= chunk_r + 1'b1;
            end
          end else begin
            step_r <= step_r + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mod_vector_seq.sv
// ============================================================================
// Module   : tb_mod_vector_seq
// Purpose  : Self-checking bench for mod_vector_seq. Directed vectors plus
//            random transactions compared against an integer-arithmetic
//            reference of the canonical residue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_vector_seq;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int WW  = 16;
  localparam int P   = 2;
  localparam int BPC = 4;
  localparam int LAT = 11;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*WW-1:0] in_vec;
  logic [W-1:0]    q_in;
  logic            signed_mode;
  logic            out_valid;
  logic            out_ready;
  logic [N*W-1:0]  out_vec;
  logic            err;

  int n_vec;
  int n_err;

  mod_vector_seq #(.N(N), .W(W), .WW(WW), .P(P), .BPC(BPC)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec      (in_vec),
    .q_in        (q_in),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_vec     (out_vec),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Canonical residue in [0, q) straight from the mathematical definition.
  function automatic logic [W-1:0] ref_mod(input logic [WW-1:0] lane,
                                           input logic sm,
                                           input logic [W-1:0] q);
    longint v;
    longint r;
    if (q == '0) return '0;
    v = sm ? longint'($signed(lane)) : longint'(lane);
    r = v % longint'(q);
    if (r < 0) r = r + longint'(q);
    return W'(r);
  endfunction

  function automatic logic [N*WW-1:0] pack4(input int a, input int b,
                                            input int c, input int d);
    logic [N*WW-1:0] v;
    v = {WW'(d), WW'(c), WW'(b), WW'(a)};
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'(1));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_err"},       64'(err),       64'(0));
    check({tag, "_out_vec"},   64'(out_vec),   64'(0));
  endtask

  // Offer one transaction, scramble the inputs while busy, check latency,
  // results, retention under backpressure, and the handshake.
  task automatic run_txn(input string tag, input logic [N*WW-1:0] vec,
                         input logic [W-1:0] q, input logic sm,
                         input int hold);
    logic [N*W-1:0] exp_vec;
    int n;
    for (int i = 0; i < N; i++)
      exp_vec[i*W +: W] = ref_mod(vec[i*WW +: WW], sm, q);

    @(negedge clk);
    check({tag, "_ready_before"}, 64'(in_ready), 64'(1));
    in_valid    = 1'b1;
    in_vec      = vec;
    q_in        = q;
    signed_mode = sm;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_ready_after"}, 64'(in_ready), 64'(0));
    n = 0;
    while (!out_valid && n < 40) begin
      in_vec      = {$urandom, $urandom};
      q_in        = W'($urandom);
      signed_mode = ~signed_mode;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n + 1), 64'((q == '0) ? 1 : LAT));
    if (!out_valid) begin
      $display("FAIL %s_timeout: got out_valid 0, expected 1", tag);
      $fatal(1, "out_valid never rose");
    end
    for (int i = 0; i < N; i++)
      check($sformatf("%s_lane%0d", tag, i), 64'(out_vec[i*W +: W]),
            64'(exp_vec[i*W +: W]));
    check({tag, "_err"}, 64'(err), 64'(q == '0));
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_vec"},   64'(out_vec),   64'(exp_vec));
      check({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_hold_ready"}, 64'(in_ready),  64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'(0));
    check({tag, "_ready_back"}, 64'(in_ready),  64'(1));
  endtask

  initial begin
    logic [N*WW-1:0] rv;
    logic [W-1:0]    rq;
    n_vec       = 0;
    n_err       = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_vec      = '0;
    q_in        = '0;
    signed_mode = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;

    run_txn("signed",   pack4(-1, 12345, -32768, -97), 8'd97,  1'b1, 0);
    run_txn("unsigned", pack4(32'hFFFF, 0, 96, 97),    8'd97,  1'b0, 0);
    run_txn("bigq",     pack4(32767, -32767, 250, -251), 8'd251, 1'b1, 0);
    run_txn("zeroq",    pack4(1234, -5, 7, 8),         8'd0,   1'b1, 0);
    run_txn("bp",       pack4(-1, 12345, -32768, -97), 8'd97,  1'b1, 20);
    run_txn("next",     pack4(5, -5, 100, -100),       8'd7,   1'b1, 0);

    // Reset in the middle of BUSY must clear outputs without waiting for a clock.
    @(negedge clk);
    in_valid    = 1'b1;
    in_vec      = pack4(-1, 2, 3, 4);
    q_in        = 8'd13;
    signed_mode = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_txn("after_rst", pack4(-32768, 32767, -1, 1), 8'd251, 1'b1, 0);

    for (int k = 0; k < 25; k++) begin
      rv = {$urandom, $urandom};
      case (k % 5)
        0:       rq = 8'd1;
        1:       rq = 8'd255;
        default: rq = W'($urandom_range(0, 255));
      endcase
      run_txn($sformatf("rand%0d", k), rv, rq, 1'($urandom), k % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_vector_seq.md
# mod_vector_seq

Sequential, parameterised successor to the combinational per-slot modular reducer. It accepts a vector of N signed or unsigned double-width products and a per-transaction runtime modulus q. It reduces every lane to its canonical residue in [0, q) using a restoring shift-subtract engine that processes P lanes per chunk and BPC bits per cycle. It sits between the vector multiplier and the RNS limb register file and trades area for latency under a valid/ready handshake.

## Interface
- N, default `N_SLOTS: lanes per vector; N % P == 0 required.
- W, default `RNS_PRIME_BITS: residue / modulus width.
- WW, default 2*`RNS_PRIME_BITS: input lane width; WW >= W.
- P, default 4: lanes reduced in parallel per chunk.
- BPC, default 4: quotient bits resolved per cycle per lane; 1 <= BPC <= WW+1.
- Derived: WWP = WW+1; STEPS = ceil(WWP/BPC); CHUNKS = N/P.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  transaction offered.
- in_ready  output  1  block can accept.
- in_vec  input  N*WW  lane i at [i*WW +: WW].
- q_in  input  W  modulus, sampled on accept.
- signed_mode  input  1  1: lanes are two's-complement; 0: unsigned. Sampled on accept.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes result.
- out_vec  output  N*W  lane i at [i*W +: W], each value in [0, q).
- err  output  1  qualified by out_valid; 1 means q was 0.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1.
  - On in_valid && in_ready, latch in_vec, q_in and signed_mode.
  - If q_in != 0, go to BUSY with chunk=0 and step=0.
  - If q_in == 0, go directly to DONE with err=1 and out_vec all zeros.
- Per-lane preparation, on chunk entry:
  - Sign-extend the lane to WWP bits if signed_mode=1; zero-extend otherwise.
  - neg = MSB of the extended value.
  - t = |value| as unsigned WWP bits.
- Restoring reduction:
  - Each BUSY cycle applies BPC iterations, with k descending from WWP-1-step*BPC. Iterations with k < 0 are skipped.
  - Each iteration: if t >= (q << k), then t -= (q << k).
  - The comparison and subtraction are evaluated at WWP+W bits, so q<<k is never truncated. This is a correctness fix over the previous generation.
- Chunk writeback, on the cycle where step == STEPS-1:
  - r = t[W-1:0].
  - Result = r if neg=0 or r=0; otherwise q - r.
  - Write the result to out_vec lanes chunk*P .. chunk*P+P-1.
  - step wraps to 0 and chunk increments.
- After the last step of chunk CHUNKS-1, go to DONE.
- DONE: out_valid=1, and out_vec and err are stable. On out_ready, go to IDLE.
- There is no overlap of transactions: in_ready=0 in both BUSY and DONE.
- Signed minimum input (-2^(WW-1)) must reduce correctly; WWP covers its magnitude.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, err=0, out_vec=0. All counters and latches are zero.
- Reset asserted in BUSY or DONE aborts the transaction immediately. No partial result is ever presented.
- Latency for q != 0:
  - Accept edge at cycle 0.
  - BUSY occupies cycles 1..CHUNKS*STEPS.
  - out_valid rises at cycle CHUNKS*STEPS+1.
- Latency for q == 0: out_valid rises at cycle 1.
- The earliest next accept is the cycle after the out_valid && out_ready edge.
- Backpressure: DONE holds indefinitely with outputs unchanged.
- in_vec and q_in may change freely after acceptance without affecting the result.
- Throughput: one vector per CHUNKS*STEPS+2 cycles with out_ready held high.

## Test plan
Bench parameters: N=4, W=8, WW=16, P=2, BPC=4. This gives STEPS=5, CHUNKS=2 and out_valid at cycle 11.

- Signed basic:
  - Stimulus: q=97, signed_mode=1, lanes {-1, 12345, -32768, -97}.
  - Required: out_vec {96, 26, 18, 0}, err=0, out_valid first high at cycle 11.
- Unsigned mode:
  - Stimulus: q=97, signed_mode=0, lanes {0xFFFF, 0, 96, 97}.
  - Required: out_vec {60, 0, 96, 0}.
- Large modulus (shift-truncation check):
  - Stimulus: q=251, signed_mode=1, lanes {32767, -32767, 250, -251}.
  - Required: out_vec {137, 114, 250, 0}.
- Zero modulus:
  - Stimulus: q=0.
  - Required: out_valid at cycle 1, err=1, out_vec=0, no BUSY cycles.
- Backpressure and retention:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid. Change in_vec and q_in during BUSY.
  - Required: out_vec unchanged and equal to the first-transaction values; in_ready=0 until after the handshake. A second transaction is accepted on the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst at cycle 5 of BUSY.
  - Required: outputs return to reset values asynchronously. A fresh transaction afterwards produces correct results with the full 11-cycle latency.
